// File: rtl/fft_frame_serializer.sv
// Ping-pong buffered serializer: captures a 16-point FFT frame in one cycle and
// streams it out point by point with a valid/ready handshake.
module fft_frame_serializer (
  input  logic        clk,
  input  logic        rst,
  input  logic        fft_valid,
  input  logic [31:0] fft_d0,
  input  logic [31:0] fft_d1,
  input  logic [31:0] fft_d2,
  input  logic [31:0] fft_d3,
  input  logic [31:0] fft_d4,
  input  logic [31:0] fft_d5,
  input  logic [31:0] fft_d6,
  input  logic [31:0] fft_d7,
  input  logic [31:0] fft_d8,
  input  logic [31:0] fft_d9,
  input  logic [31:0] fft_d10,
  input  logic [31:0] fft_d11,
  input  logic [31:0] fft_d12,
  input  logic [31:0] fft_d13,
  input  logic [31:0] fft_d14,
  input  logic [31:0] fft_d15,
  input  logic        out_ready,
  output logic        out_valid,
  output logic [31:0] out_data,
  output logic [3:0]  out_idx,
  output logic        out_last,
  output logic        overflow,
  output logic [7:0]  frame_cnt
);

  typedef enum logic {IDLE, SEND} state_t;

  state_t      state, state_nxt;
  logic [31:0] din  [16];
  logic [31:0] bank [2][16];
  logic [1:0]  full, full_nxt;
  logic        wr_ptr, rd_ptr, rd_nxt;
  logic        xfer, last_xfer, wr_free, capture, drop;

  assign din[0]  = fft_d0;
  assign din[1]  = fft_d1;
  assign din[2]  = fft_d2;
  assign din[3]  = fft_d3;
  assign din[4]  = fft_d4;
  assign din[5]  = fft_d5;
  assign din[6]  = fft_d6;
  assign din[7]  = fft_d7;
  assign din[8]  = fft_d8;
  assign din[9]  = fft_d9;
  assign din[10] = fft_d10;
  assign din[11] = fft_d11;
  assign din[12] = fft_d12;
  assign din[13] = fft_d13;
  assign din[14] = fft_d14;
  assign din[15] = fft_d15;

  assign out_valid = (state == SEND);
  assign out_data  = out_valid ? bank[rd_ptr][out_idx] : '0;
  assign out_last  = out_valid && (out_idx == 4'd15);

  always_comb begin
    xfer      = out_valid && out_ready;
    last_xfer = xfer && (out_idx == 4'd15);
    // A bank being released on this edge may be refilled on the same edge.
    wr_free   = !full[wr_ptr] || (last_xfer && (rd_ptr == wr_ptr));
    capture   = fft_valid && wr_free;
    drop      = fft_valid && !wr_free;
    full_nxt  = full;
    if (last_xfer) full_nxt[rd_ptr] = 1'b0;
    if (capture)   full_nxt[wr_ptr] = 1'b1;
    rd_nxt    = rd_ptr ^ last_xfer;
    state_nxt = state;
    case (state)
      IDLE:    if (full_nxt[rd_nxt]) state_nxt = SEND;
      SEND:    if (last_xfer && !full_nxt[rd_nxt]) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Bank contents are never reset; full flags gate their use.
  always_ff @(posedge clk) begin
    if (capture) begin
      for (int unsigned i = 0; i < 16; i++) bank[wr_ptr][i] <= din[i];
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      full      <= '0;
      wr_ptr    <= 1'b0;
      rd_ptr    <= 1'b0;
      out_idx   <= '0;
      frame_cnt <= '0;
      overflow  <= 1'b0;
    end else begin
      state  <= state_nxt;
      full   <= full_nxt;
      wr_ptr <= wr_ptr ^ capture;
      rd_ptr <= rd_nxt;
      if (xfer)      out_idx   <= out_idx + 4'd1;
      if (last_xfer) frame_cnt <= frame_cnt + 8'd1;
      if (drop)      overflow  <= 1'b1;
    end
  end

endmodule
